fifo_rd_arbiter: RTL and testbench



---
 rtl/fifo_rd_arb_pkg.sv | 30 +++
 rtl/fifo_rd_arbiter_rr_pick.sv | 34 +++
 rtl/fifo_rd_arbiter.sv | 164 ++++++++++++++++
 tb/tb_fifo_rd_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_arb_pkg.sv
// Shared types and helpers for the FIFO read-port round-robin arbiter.
// Holds the FSM state type, default parameter values and a one-hot decoder.
package fifo_rd_arb_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_BURST_W = 4;
  localparam int DEF_RD_LAT  = 1;
  localparam int DEF_TIMEOUT = 16;

  // Widest requester vector the decoder accepts
  localparam int MAX_REQ = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Converts a one-hot (or zero) vector into the index of its set bit
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (onehot[i]) begin
        idx = idx | 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first requester above the
// previous winner, wrapping around, and reports it as one-hot and as index.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_rr_last,
  output logic [N_REQ-1:0] o_winner,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any_req
);

  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  // Scan requesters starting just after the last winner, take the first one set
  always_comb begin
    o_winner  = '0;
    o_idx     = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    o_any_req = |i_req;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = IDX_W'((int'(i_rr_last) + k) % N_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found          = 1'b1;
        o_idx            = w_cand;
        o_winner[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin scheduler sharing one FIFO read port between N_REQ consumers.
// Grants one burst at a time, gates the read enable with the empty flag and
// returns per-consumer data-valid strobes aligned to the FIFO read latency.
// Optional stall timeout abort: define FIFO_RD_ARB_TIMEOUT_EN.
module fifo_rd_arbiter
  import fifo_rd_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int BURST_W = DEF_BURST_W,
  parameter int RD_LAT  = DEF_RD_LAT,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     rd_clk,
  input  logic                     rd_rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*BURST_W-1:0] req_len,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_en,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         rd_valid,
  output logic [N_REQ-1:0]         done,
  output logic                     busy,
  output logic                     err
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t         r_state;
  logic [N_REQ-1:0]   r_gnt;
  logic [N_REQ-1:0]   r_done;
  logic [IDX_W-1:0]   r_rr_last;
  logic [BURST_W-1:0] r_remaining;
  logic [N_REQ-1:0]   r_valid_sr [RD_LAT];

  logic [N_REQ-1:0]   w_pick_onehot;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_any_req;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_req_held;
  logic               w_rd_en;
  logic [BURST_W-1:0] w_len_arr [N_REQ];
  logic [BURST_W-1:0] w_pick_len;

`ifdef FIFO_RD_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT) + 1;
  logic [STALL_W-1:0] r_stall;
  logic               r_err;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req     (req),
    .i_rr_last (r_rr_last),
    .o_winner  (w_pick_onehot),
    .o_idx     (w_pick_idx),
    .o_any_req (w_any_req)
  );

  // Unpack the flat burst-length bus so the winner's length can be selected by index
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_len_arr[i] = req_len[i*BURST_W +: BURST_W];
    end
  end

  assign w_pick_len = w_len_arr[w_pick_idx];
  assign w_gnt_idx  = IDX_W'(onehot_to_idx(MAX_REQ'(r_gnt)));
  assign w_req_held = req[w_gnt_idx];
  assign w_rd_en    = (r_state == BURST) && !fifo_empty && w_req_held;

  // Arbitration FSM: pick a winner in IDLE, count reads down in BURST, end on last read or abort
  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_done      <= '0;
      r_rr_last   <= IDX_W'(N_REQ - 1);
      r_remaining <= '0;
`ifdef FIFO_RD_ARB_TIMEOUT_EN
      r_stall     <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_done <= '0;
`ifdef FIFO_RD_ARB_TIMEOUT_EN
      r_err  <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_any_req && !fifo_empty) begin
            r_state     <= BURST;
            r_gnt       <= w_pick_onehot;
            r_remaining <= (w_pick_len == '0) ? BURST_W'(1) : w_pick_len;
`ifdef FIFO_RD_ARB_TIMEOUT_EN
            r_stall     <= '0;
`endif
          end
        end
        BURST: begin
          if (!w_req_held) begin
            r_done      <= r_gnt;
            r_rr_last   <= w_gnt_idx;
            r_gnt       <= '0;
            r_remaining <= '0;
            r_state     <= IDLE;
          end else if (!fifo_empty) begin
            r_remaining <= r_remaining - BURST_W'(1);
`ifdef FIFO_RD_ARB_TIMEOUT_EN
            r_stall     <= '0;
`endif
            if (r_remaining == BURST_W'(1)) begin
              r_done    <= r_gnt;
              r_rr_last <= w_gnt_idx;
              r_gnt     <= '0;
              r_state   <= IDLE;
            end
          end
`ifdef FIFO_RD_ARB_TIMEOUT_EN
          else if (r_stall == STALL_W'(TIMEOUT - 1)) begin
            r_err       <= 1'b1;
            r_done      <= r_gnt;
            r_rr_last   <= w_gnt_idx;
            r_gnt       <= '0;
            r_remaining <= '0;
            r_stall     <= '0;
            r_state     <= IDLE;
          end else begin
            r_stall <= r_stall + STALL_W'(1);
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Delay each granted read by the FIFO latency so the strobe lines up with the data
  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_valid_sr[i] <= '0;
      end
    end else begin
      r_valid_sr[0] <= w_rd_en ? r_gnt : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        r_valid_sr[i] <= r_valid_sr[i-1];
      end
    end
  end

  assign fifo_rd_en = w_rd_en;
  assign gnt        = r_gnt;
  assign done       = r_done;
  assign rd_valid   = r_valid_sr[RD_LAT-1];
  assign busy       = (r_state != IDLE);
`ifdef FIFO_RD_ARB_TIMEOUT_EN
  assign err        = r_err;
`else
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Testbench for fifo_rd_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a burst-level behavioural model.
module tb_fifo_rd_arbiter;

  localparam int N_REQ   = 4;
  localparam int BURST_W = 4;
  localparam int RD_LAT  = 1;
  localparam int TIMEOUT = 16;

  logic                     rd_clk = 1'b0;
  logic                     rd_rst_n = 1'b0;
  logic [N_REQ-1:0]         req = '0;
  logic [N_REQ*BURST_W-1:0] req_len = '0;
  logic                     fifo_empty = 1'b1;
  logic                     fifo_rd_en;
  logic [N_REQ-1:0]         gnt;
  logic [N_REQ-1:0]         rd_valid;
  logic [N_REQ-1:0]         done;
  logic                     busy;
  logic                     err;

  int testsRun = 0;
  int testsFailed = 0;

  // Model state: burst in progress, owner, words left, last winner, pending strobes
  bit               mBusy;
  int               mGrant;
  int               mRem;
  int               mRrLast;
  int               mStall;
  logic [N_REQ-1:0] mDone;
  bit               mErr;
  logic [N_REQ-1:0] mPipe[$];

  // Observation statistics used by the directed scenarios
  int               rdEnCount;
  int               doneCount[N_REQ];
  int               validCount[N_REQ];
  int               grantLog[$];
  logic [N_REQ-1:0] prevGnt;

  fifo_rd_arbiter #(
    .N_REQ   (N_REQ),
    .BURST_W (BURST_W),
    .RD_LAT  (RD_LAT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .rd_clk     (rd_clk),
    .rd_rst_n   (rd_rst_n),
    .req        (req),
    .req_len    (req_len),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .gnt        (gnt),
    .rd_valid   (rd_valid),
    .done       (done),
    .busy       (busy),
    .err        (err)
  );

  // Free-running read clock
  initial forever #5 rd_clk = ~rd_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mBusy   = 1'b0;
    mGrant  = 0;
    mRem    = 0;
    mRrLast = N_REQ - 1;
    mStall  = 0;
    mDone   = '0;
    mErr    = 1'b0;
    mPipe.delete();
    repeat (RD_LAT) mPipe.push_back('0);
  endtask

  function automatic int lenOf(input int i);
    return int'(req_len[i*BURST_W +: BURST_W]);
  endfunction

  task automatic endBurst();
    mDone         = '0;
    mDone[mGrant] = 1'b1;
    mRrLast       = mGrant;
    mBusy         = 1'b0;
    mRem          = 0;
  endtask

  // Advance the model by one clock using the inputs present just before the edge
  task automatic modelStep(input bit rdEn);
    logic [N_REQ-1:0] m;
    m = '0;
    if (!rd_rst_n) begin
      modelReset();
      return;
    end
    if (rdEn) m[mGrant] = 1'b1;
    mPipe.push_back(m);
    void'(mPipe.pop_front());
    mDone = '0;
    mErr  = 1'b0;
    if (!mBusy) begin
      if (req != '0 && !fifo_empty) begin
        for (int k = 1; k <= N_REQ; k++) begin
          int c;
          c = (mRrLast + k) % N_REQ;
          if (req[c]) begin
            mGrant = c;
            break;
          end
        end
        mRem   = (lenOf(mGrant) == 0) ? 1 : lenOf(mGrant);
        mBusy  = 1'b1;
        mStall = 0;
      end
    end else if (!req[mGrant]) begin
      endBurst();
    end else if (!fifo_empty) begin
      mRem   = mRem - 1;
      mStall = 0;
      if (mRem == 0) endBurst();
    end
`ifdef FIFO_RD_ARB_TIMEOUT_EN
    else begin
      mStall = mStall + 1;
      if (mStall == TIMEOUT) begin
        endBurst();
        mErr = 1'b1;
      end
    end
`endif
  endtask

  // Compare every output against the model on each falling edge, then step the model
  initial begin
    logic [N_REQ-1:0] expGnt;
    bit               expRdEn;
    modelReset();
    prevGnt = '0;
    @(posedge rd_clk);
    forever begin
      @(negedge rd_clk);
      expGnt = '0;
      if (mBusy) expGnt[mGrant] = 1'b1;
      expRdEn = mBusy && !fifo_empty && req[mGrant];
      checkOutput("gnt", gnt, expGnt);
      checkOutput("fifo_rd_en", fifo_rd_en, expRdEn);
      checkOutput("rd_valid", rd_valid, mPipe[0]);
      checkOutput("done", done, mDone);
      checkOutput("busy", busy, mBusy);
      checkOutput("err", err, mErr);
      if (fifo_rd_en === 1'b1) rdEnCount++;
      for (int i = 0; i < N_REQ; i++) begin
        if (done[i] === 1'b1) doneCount[i]++;
        if (rd_valid[i] === 1'b1) validCount[i]++;
        if (gnt[i] === 1'b1 && prevGnt == '0) grantLog.push_back(i);
      end
      prevGnt = gnt;
      modelStep(expRdEn);
    end
  end

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N_REQ-1:0] r, input logic e);
    req        = r;
    fifo_empty = e;
    tick();
  endtask

  task automatic pulseReset();
    rd_rst_n   = 1'b0;
    req        = '0;
    fifo_empty = 1'b1;
    tick();
    tick();
    rd_rst_n = 1'b1;
  endtask

  task automatic clearStats();
    rdEnCount = 0;
    for (int i = 0; i < N_REQ; i++) begin
      doneCount[i]  = 0;
      validCount[i] = 0;
    end
    grantLog.delete();
  endtask

  task automatic setLen(input int i, input int v);
    req_len[i*BURST_W +: BURST_W] = BURST_W'(v);
  endtask

  task automatic setAllLen(input int v);
    for (int i = 0; i < N_REQ; i++) setLen(i, v);
  endtask

  task automatic waitDone(input int i, input int bound, input string name);
    int n;
    n = 0;
    while (done[i] !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    checkOutput(name, done[i], 1'b1);
  endtask

  task automatic waitReads(input int count, input int bound, input string name);
    int n;
    n = 0;
    while (rdEnCount < count && n < bound) begin
      tick();
      n++;
    end
    checkOutput(name, rdEnCount, count);
  endtask

  // Directed scenarios followed by randomized traffic
  initial begin
    int n;
    int emptyHold;

    // Single 3-word burst from requester 0
    pulseReset();
    clearStats();
    checkOutput("reset_gnt", gnt, 0);
    checkOutput("reset_busy", busy, 0);
    setAllLen(3);
    req        = 4'b0001;
    fifo_empty = 1'b0;
    tick();
    checkOutput("t1_gnt_after_req", gnt, 4'b0001);
    waitDone(0, 20, "t1_done_seen");
    req = '0;
    repeat (3) tick();
    checkOutput("t1_reads", rdEnCount, 3);
    checkOutput("t1_valid0", validCount[0], 3);
    checkOutput("t1_done0", doneCount[0], 1);
    checkOutput("t1_idle", busy, 0);

    // All requesting with length 1: strict rotation 0,1,2,3,0
    pulseReset();
    clearStats();
    setAllLen(1);
    req        = 4'b1111;
    fifo_empty = 1'b0;
    n = 0;
    while (grantLog.size() < 5 && n < 60) begin
      tick();
      n++;
    end
    checkOutput("t2_grant_count", grantLog.size(), 5);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t2_grant_order", (grantLog.size() > i) ? grantLog[i] : -1, i % N_REQ);
    end
    applyStimulus('0, 1'b0);
    repeat (3) tick();

    // Stall in the middle of a 4-word burst from requester 2
    pulseReset();
    clearStats();
    setLen(2, 4);
    req        = 4'b0100;
    fifo_empty = 1'b0;
    waitReads(2, 20, "t3_two_reads");
    fifo_empty = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("t3_gnt_stall", gnt, 4'b0100);
      tick();
    end
    fifo_empty = 1'b0;
    waitDone(2, 20, "t3_done_seen");
    req = '0;
    repeat (3) tick();
    checkOutput("t3_reads", rdEnCount, 4);
    checkOutput("t3_valid2", validCount[2], 4);
    checkOutput("t3_done2", doneCount[2], 1);

    // Requester 1 drops its request after two of eight words
    pulseReset();
    clearStats();
    setLen(1, 8);
    setLen(2, 2);
    req        = 4'b0010;
    fifo_empty = 1'b0;
    waitReads(2, 20, "t4_two_reads");
    req = 4'b0100;
    #1;
    checkOutput("t4_rd_en_on_drop", fifo_rd_en, 0);
    tick();
    checkOutput("t4_done1", done, 4'b0010);
    n = 0;
    while (gnt === '0 && n < 10) begin
      tick();
      n++;
    end
    checkOutput("t4_next_grant", gnt, 4'b0100);
    waitDone(2, 20, "t4_done2_seen");
    req = '0;
    repeat (3) tick();
    checkOutput("t4_valid1", validCount[1], 2);
    checkOutput("t4_done1_count", doneCount[1], 1);

    // Reset during the second word of a 5-word burst
    pulseReset();
    clearStats();
    setAllLen(1);
    setLen(3, 5);
    req        = 4'b1000;
    fifo_empty = 1'b0;
    waitReads(1, 20, "t5_first_read");
    rd_rst_n = 1'b0;
    tick();
    checkOutput("t5_gnt_reset", gnt, 0);
    checkOutput("t5_done_reset", done, 0);
    checkOutput("t5_valid_reset", rd_valid, 0);
    checkOutput("t5_busy_reset", busy, 0);
    checkOutput("t5_rd_en_reset", fifo_rd_en, 0);
    rd_rst_n = 1'b1;
    req      = 4'b1001;
    tick();
    checkOutput("t5_first_after_reset", gnt, 4'b0001);
    req = '0;
    repeat (3) tick();

    // Grant followed by a FIFO that stays empty
    pulseReset();
    clearStats();
    setLen(0, 4);
    req        = 4'b0001;
    fifo_empty = 1'b0;
    tick();
    fifo_empty = 1'b1;
`ifdef FIFO_RD_ARB_TIMEOUT_EN
    n = 0;
    while (err !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checkOutput("t6_err", err, 1);
    checkOutput("t6_done_with_err", done, 4'b0001);
    checkOutput("t6_busy_dropped", busy, 0);
`else
    repeat (100) tick();
    checkOutput("t6_gnt_held", gnt, 4'b0001);
    checkOutput("t6_busy_held", busy, 1);
    checkOutput("t6_no_reads", rdEnCount, 0);
`endif
    req = '0;
    repeat (3) tick();

    // Randomized traffic with sticky requests, random empties and rare resets
    pulseReset();
    clearStats();
    emptyHold = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(5, 0) == 0) req[$urandom_range(N_REQ-1, 0)] ^= 1'b1;
      if ($urandom_range(7, 0) == 0) req_len = ($urandom());
      if (emptyHold > 0) begin
        fifo_empty = 1'b1;
        emptyHold--;
      end else begin
        fifo_empty = ($urandom_range(3, 0) == 0);
        if ($urandom_range(199, 0) == 0) emptyHold = TIMEOUT + 4;
      end
      rd_rst_n = ($urandom_range(399, 0) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
